// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU arbiter: widths, opcodes, FSM states.
package alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned OPC_W_DEF  = 4;

  localparam logic [3:0] OPC_LSR  = 4'b0000;
  localparam logic [3:0] OPC_ADDU = 4'b0100;
  localparam logic [3:0] OPC_SUB  = 4'b0101;
  localparam logic [3:0] OPC_ADD  = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle for alu_arbiter; slave is the arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
);

  logic [1:0]          i_req_valid;
  logic [1:0]          o_req_ready;
  logic [2*OPC_W-1:0]  i_req_opcode;
  logic [2*DATA_W-1:0] i_req_op_a;
  logic [2*DATA_W-1:0] i_req_op_b;
  logic [1:0]          o_rsp_valid;
  logic [1:0]          i_rsp_ready;
  logic [DATA_W-1:0]   o_rsp_rslt;
  logic                o_rsp_zero;
  logic                o_rsp_carry;
  logic                o_rsp_ovfl;
  logic [OPC_W-1:0]    o_alu_opcode;
  logic [DATA_W-1:0]   o_alu_op_a;
  logic [DATA_W-1:0]   o_alu_op_b;
  logic [DATA_W-1:0]   i_alu_rslt;
  logic                i_alu_zero;
  logic                i_alu_carry;
  logic                i_alu_ovfl;

  modport slave (
    input  i_req_valid, i_req_opcode, i_req_op_a, i_req_op_b, i_rsp_ready,
    input  i_alu_rslt, i_alu_zero, i_alu_carry, i_alu_ovfl,
    output o_req_ready, o_rsp_valid, o_rsp_rslt, o_rsp_zero, o_rsp_carry, o_rsp_ovfl,
    output o_alu_opcode, o_alu_op_a, o_alu_op_b
  );

  modport master (
    output i_req_valid, i_req_opcode, i_req_op_a, i_req_op_b, i_rsp_ready,
    output i_alu_rslt, i_alu_zero, i_alu_carry, i_alu_ovfl,
    input  o_req_ready, o_rsp_valid, o_rsp_rslt, o_rsp_zero, o_rsp_carry, o_rsp_ovfl,
    input  o_alu_opcode, o_alu_op_a, o_alu_op_b
  );

endinterface

// File: rtl/alu_arb_grant.sv
// Two-way one-hot grant. ALU_ARB_RR_EN selects round-robin, otherwise port 0 has priority.
module alu_arb_grant (
`ifdef ALU_ARB_RR_EN
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_advance,
`endif
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

`ifdef ALU_ARB_RR_EN
  // Holds the last granted port; reset to 1 so port 0 wins the first tie.
  logic last_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else if (i_advance) begin
      last_q <= o_grant[1];
    end
  end

  always_comb begin
    o_grant = 2'b00;
    unique case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = last_q ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
`else
  always_comb begin
    o_grant = 2'b00;
    unique case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = 2'b01;
      default: o_grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: capture, execute, hold response.
// Build option: ALU_ARB_RR_EN enables round-robin arbitration (default fixed priority).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          grant;
  logic                accept;
  logic                gidx_q;
  logic [OPC_W-1:0]    opc_q;
  logic [DATA_W-1:0]   a_q, b_q, rslt_q;
  logic                zero_q, carry_q, ovfl_q;
  logic [OPC_W-1:0]    opc_sel;
  logic [DATA_W-1:0]   a_sel, b_sel;

  alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_advance (accept),
`endif
    .i_valid   (bus.i_req_valid),
    .o_grant   (grant)
  );

  assign accept  = (state_q == StIdle) && (|bus.i_req_valid);
  assign opc_sel = grant[1] ? bus.i_req_opcode[2*OPC_W-1:OPC_W] : bus.i_req_opcode[OPC_W-1:0];
  assign a_sel   = grant[1] ? bus.i_req_op_a[2*DATA_W-1:DATA_W] : bus.i_req_op_a[DATA_W-1:0];
  assign b_sel   = grant[1] ? bus.i_req_op_b[2*DATA_W-1:DATA_W] : bus.i_req_op_b[DATA_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|bus.i_req_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (bus.i_rsp_ready[gidx_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gidx_q  <= 1'b0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rslt_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      if (accept) begin
        gidx_q <= grant[1];
        opc_q  <= opc_sel;
        a_q    <= a_sel;
        b_q    <= b_sel;
      end
      if (state_q == StExec) begin
        rslt_q  <= bus.i_alu_rslt;
        zero_q  <= bus.i_alu_zero;
        carry_q <= bus.i_alu_carry;
        // Overflow is only meaningful for the signed add.
        ovfl_q  <= bus.i_alu_ovfl & (opc_q == OPC_W'(OPC_ADD));
      end
    end
  end

  always_comb begin
    bus.o_req_ready = 2'b00;
    bus.o_rsp_valid = 2'b00;
    if (state_q == StIdle) begin
      bus.o_req_ready = grant;
    end
    if (state_q == StResp) begin
      bus.o_rsp_valid = gidx_q ? 2'b10 : 2'b01;
    end
  end

  assign bus.o_alu_opcode = opc_q;
  assign bus.o_alu_op_a   = a_q;
  assign bus.o_alu_op_b   = b_q;
  assign bus.o_rsp_rslt   = rslt_q;
  assign bus.o_rsp_zero   = zero_q;
  assign bus.o_rsp_carry  = carry_q;
  assign bus.o_rsp_ovfl   = ovfl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model, directed cases, then random traffic.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32), .OPC_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .OPC_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Reference ALU: {ovfl, carry, zero, rslt}; reports overflow for every add/sub.
  function automatic logic [34:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0100, 4'b1100: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0101: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0000: r = a >> b[4:0];
      default: begin
        r = a ^ b;
        v = r[0];
      end
    endcase
    return {v, c, (r == 32'h0), r};
  endfunction

  assign {bus.i_alu_ovfl, bus.i_alu_carry, bus.i_alu_zero, bus.i_alu_rslt} =
      alu_ref(bus.o_alu_opcode, bus.o_alu_op_a, bus.o_alu_op_b);

  int passed = 0;
  int total  = 0;

  // Model: phase 0 free, 1 operation in ALU, 2 response outstanding.
  int          m_phase;
  int          m_port;
  int          m_last;
  int          m_acc;
  logic [3:0]  m_opc;
  logic [31:0] m_a, m_b, m_rslt;
  logic        m_zero, m_carry, m_ovfl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_port = 0; m_last = 1; m_acc = -1;
    m_opc = '0; m_a = '0; m_b = '0;
    m_rslt = '0; m_zero = 1'b0; m_carry = 1'b0; m_ovfl = 1'b0;
  endtask

  task automatic model_edge();
    logic [34:0] r;
    m_acc = -1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (bus.i_req_valid != 2'b00) begin
        m_port  = pick(bus.i_req_valid);
        m_last  = m_port;
        m_acc   = m_port;
        m_opc   = bus.i_req_opcode[m_port*4 +: 4];
        m_a     = bus.i_req_op_a[m_port*32 +: 32];
        m_b     = bus.i_req_op_b[m_port*32 +: 32];
        m_phase = 1;
      end
      1: begin
        r       = alu_ref(m_opc, m_a, m_b);
        m_rslt  = r[31:0];
        m_zero  = r[32];
        m_carry = r[33];
        m_ovfl  = r[34] && (m_opc == 4'b1100);
        m_phase = 2;
      end
      default: if (bus.i_rsp_ready[m_port]) m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    logic [1:0] exp_rdy, exp_rsp;
    exp_rdy = 2'b00;
    exp_rsp = 2'b00;
    if (m_phase == 0 && bus.i_req_valid != 2'b00) exp_rdy[pick(bus.i_req_valid)] = 1'b1;
    if (m_phase == 2) exp_rsp[m_port] = 1'b1;
    chk("req_ready", 64'(bus.o_req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(exp_rsp));
    chk("alu_opcode", 64'(bus.o_alu_opcode), 64'(m_opc));
    chk("alu_op_a", 64'(bus.o_alu_op_a), 64'(m_a));
    chk("alu_op_b", 64'(bus.o_alu_op_b), 64'(m_b));
    chk("rsp_rslt", 64'(bus.o_rsp_rslt), 64'(m_rslt));
    chk("rsp_flags", 64'({bus.o_rsp_zero, bus.o_rsp_carry, bus.o_rsp_ovfl}),
        64'({m_zero, m_carry, m_ovfl}));
  endtask

  // Called at a falling edge with inputs set: check, advance model, move to next falling edge.
  task automatic cyc();
    #1;
    compare_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_op(input int k, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    bus.i_req_opcode[k*4 +: 4] = op;
    bus.i_req_op_a[k*32 +: 32] = a;
    bus.i_req_op_b[k*32 +: 32] = b;
  endtask

  task automatic rand_op(input int k);
    logic [3:0]  op;
    logic [31:0] a, b;
    case ($urandom_range(4, 0))
      0: op = 4'b0100;
      1: op = 4'b0101;
      2: op = 4'b1100;
      3: op = 4'b0000;
      default: op = 4'($urandom);
    endcase
    a = $urandom;
    b = $urandom_range(3, 0) == 0 ? a : $urandom;
    if ($urandom_range(5, 0) == 0) a = 32'h7FFF_FFFF;
    set_op(k, op, a, b);
  endtask

  int exp_g[4];

  initial begin
    rst_n = 1'b0;
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
    bus.i_req_opcode = '0;
    bus.i_req_op_a = '0;
    bus.i_req_op_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    cyc();
    rst_n = 1'b1;
    chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("reset_alu_opcode", 64'(bus.o_alu_opcode), 64'd0);
    chk("reset_rslt", 64'(bus.o_rsp_rslt), 64'd0);

    // Port 0 add: 5 + 7.
    set_op(0, 4'b0100, 32'd5, 32'd7);
    bus.i_req_valid = 2'b01;
    cyc();
    bus.i_req_valid = 2'b00;
    chk("exec_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    cyc();
    chk("add_rsp_valid", 64'(bus.o_rsp_valid), 64'b01);
    chk("add_rslt", 64'(bus.o_rsp_rslt), 64'd12);
    chk("add_flags", 64'({bus.o_rsp_zero, bus.o_rsp_carry, bus.o_rsp_ovfl}), 64'd0);
    bus.i_rsp_ready = 2'b01;
    cyc();
    bus.i_rsp_ready = 2'b00;

    // Port 1 signed add overflow, then the same operands with the unsigned add.
    for (int i = 0; i < 2; i++) begin
      set_op(1, i == 0 ? 4'b1100 : 4'b0100, 32'h7FFF_FFFF, 32'd1);
      bus.i_req_valid = 2'b10;
      cyc();
      bus.i_req_valid = 2'b00;
      cyc();
      chk("ovf_rsp_valid", 64'(bus.o_rsp_valid), 64'b10);
      chk("ovf_rslt", 64'(bus.o_rsp_rslt), 64'h8000_0000);
      chk("ovf_flag", 64'(bus.o_rsp_ovfl), i == 0 ? 64'd1 : 64'd0);
      bus.i_rsp_ready = 2'b10;
      cyc();
      bus.i_rsp_ready = 2'b00;
    end

    // Both ports requesting continuously from a fresh reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    set_op(0, 4'b0100, 32'd1, 32'd1);
    set_op(1, 4'b0101, 32'd9, 32'd4);
    bus.i_req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("both_grant", 64'(bus.o_req_ready), 64'(2'b01 << exp_g[i]));
      cyc();
      cyc();
      bus.i_rsp_ready = 2'b11;
      cyc();
      bus.i_rsp_ready = 2'b00;
    end
    bus.i_req_valid = 2'b00;
    cyc();

    // Backpressure on port 0 while port 1 waits.
    set_op(0, 4'b0100, 32'd100, 32'd23);
    bus.i_req_valid = 2'b01;
    cyc();
    set_op(1, 4'b0101, 32'd50, 32'd8);
    bus.i_req_valid = 2'b10;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp_valid", 64'(bus.o_rsp_valid), 64'b01);
      chk("bp_rslt", 64'(bus.o_rsp_rslt), 64'd123);
      chk("bp_req_ready", 64'(bus.o_req_ready), 64'b00);
      cyc();
    end
    bus.i_rsp_ready = 2'b01;
    cyc();
    bus.i_rsp_ready = 2'b00;
    #1;
    chk("bp_port1_accept", 64'(bus.o_req_ready), 64'b10);
    cyc();
    bus.i_req_valid = 2'b00;
    cyc();
    chk("bp_port1_rslt", 64'(bus.o_rsp_rslt), 64'd42);
    bus.i_rsp_ready = 2'b10;
    cyc();
    bus.i_rsp_ready = 2'b00;

    // Subtraction to zero.
    set_op(0, 4'b0101, 32'h1234, 32'h1234);
    bus.i_req_valid = 2'b01;
    cyc();
    bus.i_req_valid = 2'b00;
    cyc();
    chk("zero_rslt", 64'(bus.o_rsp_rslt), 64'd0);
    chk("zero_flag", 64'(bus.o_rsp_zero), 64'd1);
    bus.i_rsp_ready = 2'b01;
    cyc();
    bus.i_rsp_ready = 2'b00;

    // Reset while the operation is in EXEC; request stays pending.
    set_op(0, 4'b1100, 32'd3, 32'd4);
    bus.i_req_valid = 2'b01;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_exec_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_exec_opcode", 64'(bus.o_alu_opcode), 64'd0);
    chk("rst_exec_reaccept", 64'(bus.o_req_ready), 64'b01);
    cyc();
    bus.i_req_valid = 2'b00;
    cyc();
    chk("rst_exec_rslt", 64'(bus.o_rsp_rslt), 64'd7);
    bus.i_rsp_ready = 2'b01;
    cyc();
    bus.i_rsp_ready = 2'b00;

    // Random traffic; requesters hold operands until accepted.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (m_acc == k) begin
          if ($urandom_range(1, 0) == 0) bus.i_req_valid[k] = 1'b0;
          else rand_op(k);
        end else if (!bus.i_req_valid[k] && $urandom_range(2, 0) == 0) begin
          bus.i_req_valid[k] = 1'b1;
          rand_op(k);
        end
      end
      bus.i_rsp_ready = 2'($urandom_range(3, 0));
      rst_n = ($urandom_range(149, 0) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single EX-stage ALU between two requesters (port 0: pipeline EX issue, port 1: debug/auxiliary unit) over valid/ready handshakes. Captures one request at a time into operand registers, drives the ALU for one full cycle, registers its flags and result, and holds the response until the granted requester accepts it. Sits between the requesters and the ALU; the ALU itself stays purely combinational.

## Interface
- DATA_W, 32, operand/result width
- OPC_W, 4, ALU opcode width
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_req_valid  in  2  bit k: requester k presents an operation
- o_req_ready  out  2  bit k: one-cycle accept pulse to requester k
- i_req_opcode  in  2*OPC_W  [k*OPC_W +: OPC_W] opcode of requester k
- i_req_op_a, i_req_op_b  in  2*DATA_W  [k*DATA_W +: DATA_W] operands of requester k
- o_rsp_valid  out  2  bit k: response pending for requester k
- i_rsp_ready  in  2  bit k: requester k accepts response
- o_rsp_rslt  out  DATA_W  registered result, shared by both ports
- o_rsp_zero, o_rsp_carry, o_rsp_ovfl  out  1 each  registered flags
- o_alu_opcode  out  OPC_W  to ALU
- o_alu_op_a, o_alu_op_b  out  DATA_W  to ALU
- i_alu_rslt  in  DATA_W  from ALU
- i_alu_zero, i_alu_carry, i_alu_ovfl  in  1 each  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any i_req_valid, grant one (see arbitration), pulse o_req_ready[g]=1 this cycle, capture opcode/op_a/op_b of g and grant index into registers, go EXEC. No request: stay IDLE.
- EXEC: o_alu_* driven from capture registers; at cycle end register i_alu_rslt, i_alu_zero, i_alu_carry into response registers, go RESP.
- Overflow masking: o_rsp_ovfl = i_alu_ovfl only if captured opcode == 4'b1100 (signed ADD), else 0.
- RESP: o_rsp_valid[g]=1, other bit 0; hold all response outputs stable. On i_rsp_ready[g]=1 go IDLE. i_rsp_ready of non-granted port ignored.
- o_req_ready is 0 in EXEC and RESP; requests there are not accepted and must be held by the requester.
- o_alu_* always reflect capture registers (stable outside IDLE capture edge).
- Arbitration: see Configuration. Single requester valid always wins regardless of mode.
- Reset values: state IDLE, o_req_ready=0, o_rsp_valid=0, capture registers 0 (o_alu_opcode=0, op_a=op_b=0), response registers 0, RR pointer selects port 0 first.
- Reset mid-operation (EXEC or RESP): in-flight op dropped, no response issued, IDLE next cycle.

## Timing
- Accept handshake at edge N (o_req_ready & i_req_valid) -> EXEC during N+1 -> o_rsp_valid high from N+2.
- Minimum issue interval 3 cycles: response accepted at edge M -> IDLE at M+1 -> next accept no earlier than M+1.
- Response held indefinitely while i_rsp_ready[g]=0.
- No combinational path from i_req_* or i_rsp_ready to any output; o_req_ready depends on state and i_req_valid only.

## Configuration
- ALU_ARB_RR_EN defined: round-robin; pointer holds last-granted port; when both valid in IDLE, grant port != last granted; pointer updates on each grant.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins when both valid; pointer logic absent.

## Structure
- Shared package (alu_pkg): ALU opcode constants (LSR 0000 ... ADD 1100, OPC_ADD used for overflow masking), DATA_W/OPC_W defaults, FSM state enum (IDLE/EXEC/RESP).
- One sub-module: alu_arb_grant (2-way grant logic, round-robin or fixed per macro), output one-hot grant.
- ALU instantiated outside this block, at the EX stage level.

## Test plan
- Port 0 only: opcode 4'b0100, A=5, B=7, accept at N -> o_rsp_valid[0]=1 at N+2, rslt=12, zero=0, carry=0, ovfl=0.
- Overflow: port 1, opcode 4'b1100, A=32'h7FFF_FFFF, B=1 -> rslt=32'h8000_0000, ovfl=1; same operands opcode 4'b0100 -> ovfl=0.
- Both valid every IDLE, 4 ops: with ALU_ARB_RR_EN grants 0,1,0,1; without it grants 0,0,0,0 and port 1 starved.
- Backpressure: i_rsp_ready[0]=0 for 5 cycles during RESP -> o_rsp_valid[0] and rslt stable, o_req_ready=2'b00 throughout, port 1 accepted 1 cycle after release.
- Zero flag: opcode 4'b0101, A=B=32'h1234 -> rslt=0, zero=1.
- Reset in EXEC: i_rst_n=0 one cycle -> next cycle o_rsp_valid=0, o_alu_opcode=0, state IDLE; pending request accepted the following cycle.
